// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and helpers for the multiply/divide controller.
package muldiv_ctrl_pkg;

   localparam int MULDIV_OP_W = 2;

   typedef enum logic [MULDIV_OP_W-1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic op_is_div(input logic [MULDIV_OP_W-1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [MULDIV_OP_W-1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_ctrl_core.sv
// One combinational iteration of the shared datapath: add-shift for multiply,
// restoring subtract-shift for divide.
module muldiv_ctrl_core #(
   parameter int WIDTH = 32
) (
   input  logic             mode,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] opnd_in,
   input  logic [WIDTH-1:0] mult_in,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] opnd_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             no_borrow;

   // Partial remainder is always below the divisor, so the low WIDTH bits of the
   // difference are exact whenever the trial subtract succeeds.
   always_comb begin
      sum       = opnd_in[0] ? ({1'b0, acc_in} + {1'b0, mult_in}) : {1'b0, acc_in};
      shifted   = {acc_in, opnd_in[WIDTH-1]};
      no_borrow = (shifted >= {1'b0, mult_in});
      diff      = shifted[WIDTH-1:0] - mult_in;
      if (mode) begin
         acc_out  = no_borrow ? diff : shifted[WIDTH-1:0];
         opnd_out = {opnd_in[WIDTH-2:0], no_borrow};
      end else begin
         acc_out  = sum[WIDTH:1];
         opnd_out = {sum[0], opnd_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: FSM, iteration counter, sign handling and
// registered HI/LO result with a one-cycle write strobe.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [MULDIV_OP_W-1:0] op,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       src1,
   input  logic [WIDTH-1:0]       src2,
   output logic                   stallreq,
   output logic                   hilo_we,
   output logic [WIDTH-1:0]       hi,
   output logic [WIDTH-1:0]       lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_e           state;
   logic [CW-1:0]    count;
   logic             is_div, is_div0, neg_res, neg_rem;
   logic [WIDTH-1:0] mag_a, mag_b, acc, opnd;
   logic [WIDTH-1:0] acc_nxt, opnd_nxt;
   logic             a_neg, b_neg, div0;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] res_hi, res_lo;

   assign a_neg = op_is_signed(op) & src1[WIDTH-1];
   assign b_neg = op_is_signed(op) & src2[WIDTH-1];
   assign abs_a = a_neg ? -src1 : src1;
   assign abs_b = b_neg ? -src2 : src2;
   assign div0  = op_is_div(op) && (src2 == '0);

   assign stallreq = (rst && state == ST_IDLE && start && !flush) || (state == ST_BUSY);

   muldiv_ctrl_core #(.WIDTH(WIDTH)) u_core (
      .mode     (is_div),
      .acc_in   (acc),
      .opnd_in  (opnd),
      .mult_in  (is_div ? mag_b : mag_a),
      .acc_out  (acc_nxt),
      .opnd_out (opnd_nxt)
   );

   // Final sign fix-up on the magnitudes produced by the last iteration.
   always_comb begin
      prod_fix = neg_res ? -{acc_nxt, opnd_nxt} : {acc_nxt, opnd_nxt};
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (is_div0) begin
         res_hi = neg_rem ? -mag_a : mag_a;
         res_lo = '1;
      end else if (is_div) begin
         res_hi = neg_rem ? -acc_nxt : acc_nxt;
         res_lo = neg_res ? -opnd_nxt : opnd_nxt;
      end
   end

   // Divide-by-zero takes a single BUSY pass with the counter preset to the last step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         count   <= '0;
         is_div  <= 1'b0;
         is_div0 <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         mag_a   <= '0;
         mag_b   <= '0;
         acc     <= '0;
         opnd    <= '0;
         hilo_we <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         hilo_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  is_div  <= op_is_div(op);
                  is_div0 <= div0;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  acc     <= '0;
                  opnd    <= op_is_div(op) ? abs_a : abs_b;
                  count   <= div0 ? CW'(WIDTH - 1) : '0;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else begin
                  acc   <= acc_nxt;
                  opnd  <= opnd_nxt;
                  count <= count + CW'(1);
                  if (count == CW'(WIDTH - 1)) begin
                     state   <= ST_DONE;
                     hi      <= res_hi;
                     lo      <= res_lo;
                     hilo_we <= 1'b1;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall window, signed/unsigned results,
// divide-by-zero, overflow, flush and asynchronous reset.
module tb_muldiv_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic        flush;
   logic [31:0] src1, src2;
   logic        stallreq, hilo_we;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .flush    (flush),
      .src1     (src1),
      .src2     (src2),
      .stallreq (stallreq),
      .hilo_we  (hilo_we),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issues one op at the current cycle (cycle 0) and follows it until hilo_we.
   task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp_res, input int exp_cycle, input string tag);
      int c;
      int stall_bad;
      bit seen;
      stall_bad = 0;
      seen      = 1'b0;
      op    = o;
      src1  = a;
      src2  = b;
      start = 1'b1;
      for (c = 0; c < 60; c++) begin
         @(negedge clk);
         if (stallreq !== (c < exp_cycle)) stall_bad++;
         if (hilo_we === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check_output({tag, " seen"}, 64'(seen), 64'(1));
      check_output({tag, " cycle"}, 64'(c), 64'(exp_cycle));
      check_output({tag, " stall"}, 64'(stall_bad), 64'(0));
      check_output({tag, " hilo"}, {hi, lo}, exp_res);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int pulses;
      rst   = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 2'b00;
      src1  = '0;
      src2  = '0;
      #23;
      check_output("reset stallreq", 64'(stallreq), 64'(0));
      check_output("reset hilo_we", 64'(hilo_we), 64'(0));
      check_output("reset hilo", {hi, lo}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, "multu max");
      @(negedge clk);
      check_output("pulse width", 64'(hilo_we), 64'(0));
      check_output("hold hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      @(posedge clk); #1;

      apply_stimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 33, "mult -1*-1");
      apply_stimulus(2'b00, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000, 33, "mult min*2");
      apply_stimulus(2'b00, 32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 33, "mult 3*-5");
      apply_stimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, "div -7/2");
      apply_stimulus(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, "div 7/-2");
      apply_stimulus(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, "divu 100/7");
      apply_stimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, "div ovf");
      apply_stimulus(2'b11, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 2, "divu 5/0");
      apply_stimulus(2'b10, 32'hFFFF_FFF8, 32'd0, 64'hFFFF_FFF8_FFFF_FFFF, 2, "div -8/0");

      // Flush a DIV in its tenth cycle; HI/LO must keep the previous result.
      op    = 2'b10;
      src1  = 32'd1000;
      src2  = 32'd3;
      start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check_output("flush busy stall", 64'(stallreq), 64'(1));
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check_output("flush idle stall", 64'(stallreq), 64'(0));
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hilo_we === 1'b1) pulses++;
      end
      check_output("flush no write", 64'(pulses), 64'(0));
      check_output("flush hold hilo", {hi, lo}, 64'hFFFF_FFF8_FFFF_FFFF);

      // Start and flush together in IDLE: nothing latched.
      @(posedge clk); #1;
      op    = 2'b01;
      src1  = 32'd9;
      src2  = 32'd9;
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check_output("start+flush stall", 64'(stallreq), 64'(0));
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      check_output("start+flush idle", 64'(stallreq), 64'(0));
      @(posedge clk); #1;

      // Back-to-back MULT then DIVU with start held continuously.
      apply_stimulus(2'b00, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 33, "b2b mult");
      apply_stimulus(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 33, "b2b divu");

      // Asynchronous reset in the middle of a multiply.
      op    = 2'b00;
      src1  = 32'd12345;
      src2  = 32'd678;
      start = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      check_output("midrst stallreq", 64'(stallreq), 64'(0));
      check_output("midrst hilo_we", 64'(hilo_we), 64'(0));
      check_output("midrst hilo", {hi, lo}, 64'h0);
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (hilo_we === 1'b1) pulses++;
      end
      check_output("midrst no write", 64'(pulses), 64'(0));
      @(posedge clk); #1;
      apply_stimulus(2'b00, 32'd12345, 32'd678, 64'd8369910, 33, "post-reset mult");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
